// File: rtl/cp0_tlb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cp0_tlb_ctrl
// Brief    : CP0 TLB register file, TLBP/TLBR absorption and TLB exception
//            handshake for the M stage.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_tlb_ctrl #(
    parameter int TLB_LINE  = 32,
    parameter int TLB_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  tlb_type,
    input  logic        tlb_valid,
    input  logic        mtc0_en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic [31:0] EntryHi_o,
    output logic [31:0] PageMask_o,
    output logic [31:0] EntryLo0_o,
    output logic [31:0] EntryLo1_o,
    output logic [31:0] Index_o,
    output logic [31:0] Random_o,
    input  logic [31:0] EntryHi_t,
    input  logic [31:0] PageMask_t,
    input  logic [31:0] EntryLo0_t,
    input  logic [31:0] EntryLo1_t,
    input  logic [31:0] Index_t,
    input  logic        inst_req,
    input  logic [31:0] inst_vaddr,
    input  logic        inst_found,
    input  logic        inst_V,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_vaddr,
    input  logic        data_found,
    input  logic        data_V,
    input  logic        data_D,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic        exc_refill,
    output logic [31:0] exc_vaddr,
    input  logic        exc_ack,
    input  logic        flush
);

    // TLBWI/TLBWR change no CP0 state, so only these two codes are decoded.
    localparam logic [2:0] c_TLBP = 3'd1;
    localparam logic [2:0] c_TLBR = 3'd2;

    localparam logic [4:0] c_ADDR_INDEX    = 5'd0;
    localparam logic [4:0] c_ADDR_RANDOM   = 5'd1;
    localparam logic [4:0] c_ADDR_ENTRYLO0 = 5'd2;
    localparam logic [4:0] c_ADDR_ENTRYLO1 = 5'd3;
    localparam logic [4:0] c_ADDR_CONTEXT  = 5'd4;
    localparam logic [4:0] c_ADDR_PAGEMASK = 5'd5;
    localparam logic [4:0] c_ADDR_WIRED    = 5'd6;
    localparam logic [4:0] c_ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] c_ADDR_ENTRYHI  = 5'd10;

    localparam logic [4:0] c_EXC_MOD  = 5'd1;
    localparam logic [4:0] c_EXC_TLBL = 5'd2;
    localparam logic [4:0] c_EXC_TLBS = 5'd3;

    localparam logic [TLB_WIDTH-1:0] c_RAND_TOP = TLB_WIDTH'(TLB_LINE - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_index_p;
    logic [TLB_WIDTH-1:0]  r_index_field;
    logic [TLB_WIDTH-1:0]  r_random;
    logic [TLB_WIDTH-1:0]  r_wired;
    logic [29:0]           r_entrylo0;
    logic [29:0]           r_entrylo1;
    logic [8:0]            r_ctx_ptebase;
    logic [18:0]           r_ctx_badvpn2;
    logic [15:0]           r_pagemask;
    logic [18:0]           r_ehi_vpn2;
    logic [7:0]            r_ehi_asid;
    logic [31:0]           r_badvaddr;

    logic [4:0]            r_exc_code;
    logic                  r_exc_refill;
    logic [31:0]           r_exc_vaddr;
    logic [4:0]            w_exc_code_nxt;
    logic                  w_exc_refill_nxt;
    logic [31:0]           w_exc_vaddr_nxt;
    logic                  w_ack_take;

    logic                  w_tlbp;
    logic                  w_tlbr;
    logic                  w_wr_index;
    logic                  w_wr_lo0;
    logic                  w_wr_lo1;
    logic                  w_wr_context;
    logic                  w_wr_pagemask;
    logic                  w_wr_wired;
    logic                  w_wr_entryhi;

    logic                  w_inst_fault;
    logic                  w_data_fault;
    logic                  w_fault;
    logic [4:0]            w_det_code;
    logic                  w_det_refill;
    logic [31:0]           w_det_vaddr;

    logic                  w_unused_bits;

    assign w_unused_bits = ^{EntryHi_t[12:8], PageMask_t[31:29], PageMask_t[12:0],
                             EntryLo0_t[31:30], EntryLo1_t[31:30], Index_t[30:TLB_WIDTH]};

    assign w_tlbp        = tlb_valid && (tlb_type == c_TLBP);
    assign w_tlbr        = tlb_valid && (tlb_type == c_TLBR);
    assign w_wr_index    = mtc0_en && (cp0_addr == c_ADDR_INDEX);
    assign w_wr_lo0      = mtc0_en && (cp0_addr == c_ADDR_ENTRYLO0);
    assign w_wr_lo1      = mtc0_en && (cp0_addr == c_ADDR_ENTRYLO1);
    assign w_wr_context  = mtc0_en && (cp0_addr == c_ADDR_CONTEXT);
    assign w_wr_pagemask = mtc0_en && (cp0_addr == c_ADDR_PAGEMASK);
    assign w_wr_wired    = mtc0_en && (cp0_addr == c_ADDR_WIRED);
    assign w_wr_entryhi  = mtc0_en && (cp0_addr == c_ADDR_ENTRYHI);

    // kseg0/kseg1 (vaddr[31:30] == 2'b10) bypass translation and never fault.
    assign w_inst_fault = inst_req && (inst_vaddr[31:30] != 2'b10) && (!inst_found || !inst_V);
    assign w_data_fault = data_req && (data_vaddr[31:30] != 2'b10) && (tlb_type != c_TLBP) &&
                          (!data_found || !data_V || (data_wr && !data_D));
    assign w_fault      = w_inst_fault || w_data_fault;

    always_comb begin
        w_det_code   = c_EXC_TLBL;
        w_det_refill = 1'b0;
        w_det_vaddr  = data_vaddr;
        if (w_inst_fault) begin
            w_det_refill = !inst_found;
            w_det_vaddr  = inst_vaddr;
        end else if (!data_found || !data_V) begin
            w_det_code   = data_wr ? c_EXC_TLBS : c_EXC_TLBL;
            w_det_refill = !data_found;
        end else begin
            w_det_code   = c_EXC_MOD;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_exc_code_nxt   = r_exc_code;
        w_exc_refill_nxt = r_exc_refill;
        w_exc_vaddr_nxt  = r_exc_vaddr;
        w_ack_take       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fault && !flush) begin
                    w_state_nxt      = S_PEND;
                    w_exc_code_nxt   = w_det_code;
                    w_exc_refill_nxt = w_det_refill;
                    w_exc_vaddr_nxt  = w_det_vaddr;
                end
            end
            S_PEND: begin
                if (flush) begin
                    w_state_nxt      = S_IDLE;
                    w_exc_code_nxt   = 5'd0;
                    w_exc_refill_nxt = 1'b0;
                    w_exc_vaddr_nxt  = 32'd0;
                end else if (exc_ack) begin
                    w_ack_take = 1'b1;
                    if (w_fault) begin
                        w_state_nxt      = S_PEND;
                        w_exc_code_nxt   = w_det_code;
                        w_exc_refill_nxt = w_det_refill;
                        w_exc_vaddr_nxt  = w_det_vaddr;
                    end else begin
                        w_state_nxt      = S_IDLE;
                        w_exc_code_nxt   = 5'd0;
                        w_exc_refill_nxt = 1'b0;
                        w_exc_vaddr_nxt  = 32'd0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_exc_code   <= 5'd0;
            r_exc_refill <= 1'b0;
            r_exc_vaddr  <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_exc_code   <= w_exc_code_nxt;
            r_exc_refill <= w_exc_refill_nxt;
            r_exc_vaddr  <= w_exc_vaddr_nxt;
        end
    end

    // Per register: exception ack beats TLB op beats mtc0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index_p     <= 1'b0;
            r_index_field <= '0;
            r_random      <= c_RAND_TOP;
            r_wired       <= '0;
            r_entrylo0    <= 30'd0;
            r_entrylo1    <= 30'd0;
            r_ctx_ptebase <= 9'd0;
            r_ctx_badvpn2 <= 19'd0;
            r_pagemask    <= 16'd0;
            r_ehi_vpn2    <= 19'd0;
            r_ehi_asid    <= 8'd0;
            r_badvaddr    <= 32'd0;
        end else begin
            if (w_tlbp) begin
                r_index_p     <= Index_t[31];
                r_index_field <= Index_t[31] ? '0 : Index_t[TLB_WIDTH-1:0];
            end else if (w_wr_index) begin
                r_index_field <= cp0_wdata[TLB_WIDTH-1:0];
            end

            if (w_wr_wired || (r_random == r_wired)) begin
                r_random <= c_RAND_TOP;
            end else begin
                r_random <= r_random - TLB_WIDTH'(1);
            end

            if (w_wr_wired) begin
                r_wired <= cp0_wdata[TLB_WIDTH-1:0];
            end

            if (w_tlbr) begin
                r_entrylo0 <= EntryLo0_t[29:0];
                r_entrylo1 <= EntryLo1_t[29:0];
                r_pagemask <= PageMask_t[28:13];
            end else begin
                if (w_wr_lo0)      r_entrylo0 <= cp0_wdata[29:0];
                if (w_wr_lo1)      r_entrylo1 <= cp0_wdata[29:0];
                if (w_wr_pagemask) r_pagemask <= cp0_wdata[28:13];
            end

            if (w_ack_take) begin
                r_ctx_badvpn2 <= r_exc_vaddr[31:13];
            end else if (w_wr_context) begin
                r_ctx_ptebase <= cp0_wdata[31:23];
            end

            if (w_ack_take) begin
                r_ehi_vpn2 <= r_exc_vaddr[31:13];
            end else if (w_tlbr) begin
                r_ehi_vpn2 <= EntryHi_t[31:13];
                r_ehi_asid <= EntryHi_t[7:0];
            end else if (w_wr_entryhi) begin
                r_ehi_vpn2 <= cp0_wdata[31:13];
                r_ehi_asid <= cp0_wdata[7:0];
            end

            if (w_ack_take) begin
                r_badvaddr <= r_exc_vaddr;
            end
        end
    end

    assign Index_o    = {r_index_p, {(31-TLB_WIDTH){1'b0}}, r_index_field};
    assign Random_o   = {{(32-TLB_WIDTH){1'b0}}, r_random};
    assign EntryLo0_o = {2'b00, r_entrylo0};
    assign EntryLo1_o = {2'b00, r_entrylo1};
    assign PageMask_o = {3'b000, r_pagemask, 13'd0};
    assign EntryHi_o  = {r_ehi_vpn2, 5'd0, r_ehi_asid};

    assign exc_valid  = (r_state == S_PEND);
    assign exc_code   = r_exc_code;
    assign exc_refill = r_exc_refill;
    assign exc_vaddr  = r_exc_vaddr;

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            c_ADDR_INDEX:    cp0_rdata = Index_o;
            c_ADDR_RANDOM:   cp0_rdata = Random_o;
            c_ADDR_ENTRYLO0: cp0_rdata = EntryLo0_o;
            c_ADDR_ENTRYLO1: cp0_rdata = EntryLo1_o;
            c_ADDR_CONTEXT:  cp0_rdata = {r_ctx_ptebase, r_ctx_badvpn2, 4'd0};
            c_ADDR_PAGEMASK: cp0_rdata = PageMask_o;
            c_ADDR_WIRED:    cp0_rdata = {{(32-TLB_WIDTH){1'b0}}, r_wired};
            c_ADDR_BADVADDR: cp0_rdata = r_badvaddr;
            c_ADDR_ENTRYHI:  cp0_rdata = EntryHi_o;
            default:         cp0_rdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_tlb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_tlb_ctrl
// Brief    : Directed self-checking bench for cp0_tlb_ctrl using an expected-
//            value queue and immediate assertions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_tlb_ctrl;

    localparam int TLB_LINE  = 32;
    localparam int TLB_WIDTH = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  tlb_type = '0;
    logic        tlb_valid = 1'b0;
    logic        mtc0_en = 1'b0;
    logic [4:0]  cp0_addr = '0;
    logic [31:0] cp0_wdata = '0;
    logic [31:0] cp0_rdata;
    logic [31:0] EntryHi_o, PageMask_o, EntryLo0_o, EntryLo1_o, Index_o, Random_o;
    logic [31:0] EntryHi_t = '0, PageMask_t = '0, EntryLo0_t = '0, EntryLo1_t = '0, Index_t = '0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_vaddr = '0;
    logic        inst_found = 1'b0, inst_V = 1'b0;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [31:0] data_vaddr = '0;
    logic        data_found = 1'b0, data_V = 1'b0, data_D = 1'b0;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        exc_refill;
    logic [31:0] exc_vaddr;
    logic        exc_ack = 1'b0;
    logic        flush = 1'b0;

    always #5 clk = ~clk;

    cp0_tlb_ctrl #(.TLB_LINE(TLB_LINE), .TLB_WIDTH(TLB_WIDTH)) dut (
        .clk(clk), .rst(rst), .tlb_type(tlb_type), .tlb_valid(tlb_valid),
        .mtc0_en(mtc0_en), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .EntryHi_o(EntryHi_o), .PageMask_o(PageMask_o), .EntryLo0_o(EntryLo0_o),
        .EntryLo1_o(EntryLo1_o), .Index_o(Index_o), .Random_o(Random_o),
        .EntryHi_t(EntryHi_t), .PageMask_t(PageMask_t), .EntryLo0_t(EntryLo0_t),
        .EntryLo1_t(EntryLo1_t), .Index_t(Index_t),
        .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_found(inst_found), .inst_V(inst_V),
        .data_req(data_req), .data_wr(data_wr), .data_vaddr(data_vaddr),
        .data_found(data_found), .data_V(data_V), .data_D(data_D),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_refill(exc_refill), .exc_vaddr(exc_vaddr),
        .exc_ack(exc_ack), .flush(flush)
    );

    int          checks = 0;
    int          errors = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          rnd_m;
    int          wired_m;

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow observed=%h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] v);
        expect_val(tag, v);
        cp0_addr = a;
        #1;
        check(cp0_rdata);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_en   = 1'b1;
        cp0_addr  = a;
        cp0_wdata = d;
    endtask

    task automatic quiet();
        tlb_valid = 1'b0;
        tlb_type  = 3'd0;
        mtc0_en   = 1'b0;
        inst_req  = 1'b0;
        data_req  = 1'b0;
        exc_ack   = 1'b0;
        flush     = 1'b0;
    endtask

    function automatic logic [31:0] exc_bundle(input logic v, input logic r, input logic [4:0] c);
        return {25'd0, v, r, c};
    endfunction

    initial begin
        // ---------------- reset state
        tick();
        tick();
        expect_val("rst_random", 32'h0000_001F);   check(Random_o);
        expect_val("rst_index", 32'h0);            check(Index_o);
        expect_val("rst_exc", 32'h0);              check(exc_bundle(exc_valid, exc_refill, exc_code));
        expect_val("rst_exc_vaddr", 32'h0);        check(exc_vaddr);
        read_check("rst_entryhi", 5'd10, 32'h0);
        read_check("rst_mfc0_random", 5'd1, 32'h0000_001F);
        rst = 1'b0;

        // ---------------- Random with Wired=0
        rnd_m   = TLB_LINE - 1;
        wired_m = 0;
        for (int i = 0; i < 40; i++) begin
            rnd_m = (rnd_m == wired_m) ? TLB_LINE - 1 : rnd_m - 1;
            expect_val("random_w0", 32'(rnd_m));
            tick();
            check(Random_o);
        end

        // ---------------- Random with Wired=8
        mtc0(5'd6, 32'd8);
        rnd_m   = TLB_LINE - 1;
        wired_m = 8;
        expect_val("random_wired_wr", 32'(rnd_m));
        tick();
        quiet();
        check(Random_o);
        for (int i = 0; i < 30; i++) begin
            rnd_m = (rnd_m == wired_m) ? TLB_LINE - 1 : rnd_m - 1;
            expect_val("random_w8", 32'(rnd_m));
            tick();
            check(Random_o);
        end
        read_check("mfc0_wired", 5'd6, 32'd8);

        // ---------------- Wired = TLB_LINE-1 holds Random at the top
        mtc0(5'd6, 32'hFFFF_FFFF);
        tick();
        quiet();
        for (int i = 0; i < 3; i++) begin
            expect_val("random_hold", 32'h0000_001F);
            tick();
            check(Random_o);
        end
        mtc0(5'd6, 32'd0);
        tick();
        quiet();

        // ---------------- writable masks
        mtc0(5'd10, 32'hFFFF_FFFF);
        tick();
        quiet();
        read_check("mask_entryhi", 5'd10, 32'hFFFF_E0FF);
        expect_val("entryhi_o", 32'hFFFF_E0FF);    check(EntryHi_o);

        mtc0(5'd0, 32'hFFFF_FFFF);
        tick();
        quiet();
        read_check("mask_index", 5'd0, 32'h0000_001F);

        mtc0(5'd4, 32'hFFFF_FFFF);
        tick();
        quiet();
        read_check("mask_context", 5'd4, 32'hFF80_0000);
        read_check("unmapped_addr", 5'd7, 32'h0);

        // ---------------- TLBP miss beats a same-edge mtc0 Index
        tlb_valid = 1'b1;
        tlb_type  = 3'd1;
        Index_t   = 32'h8000_0000;
        mtc0(5'd0, 32'd5);
        tick();
        quiet();
        read_check("tlbp_miss", 5'd0, 32'h8000_0000);

        tlb_valid = 1'b1;
        tlb_type  = 3'd1;
        Index_t   = 32'h0000_0007;
        tick();
        quiet();
        read_check("tlbp_hit", 5'd0, 32'h0000_0007);

        // ---------------- TLBR masks, beats mtc0 EntryHi
        tlb_valid  = 1'b1;
        tlb_type   = 3'd2;
        EntryHi_t  = 32'h1234_5678;
        PageMask_t = 32'hFFFF_FFFF;
        EntryLo0_t = 32'hFFFF_FFFF;
        EntryLo1_t = 32'h4000_0001;
        mtc0(5'd10, 32'h0);
        tick();
        quiet();
        read_check("tlbr_lo0", 5'd2, 32'h3FFF_FFFF);
        read_check("tlbr_lo1", 5'd3, 32'h0000_0001);
        read_check("tlbr_pagemask", 5'd5, 32'h1FFF_E000);
        read_check("tlbr_entryhi", 5'd10, 32'h1234_4078);

        tlb_valid  = 1'b1;
        tlb_type   = 3'd3;
        EntryLo0_t = 32'h0;
        tick();
        quiet();
        read_check("tlbwi_nochange", 5'd2, 32'h3FFF_FFFF);

        tlb_valid = 1'b0;
        tlb_type  = 3'd2;
        tick();
        quiet();
        read_check("tlbr_invalid", 5'd2, 32'h3FFF_FFFF);

        // ---------------- data store refill fault
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_vaddr = 32'h0040_2000;
        data_found = 1'b0;
        data_V     = 1'b0;
        data_D     = 1'b0;
        expect_val("tlbs_refill", exc_bundle(1'b1, 1'b1, 5'd3));
        expect_val("tlbs_vaddr", 32'h0040_2000);
        tick();
        quiet();
        check(exc_bundle(exc_valid, exc_refill, exc_code));
        check(exc_vaddr);

        inst_req   = 1'b1;
        inst_vaddr = 32'h0000_2000;
        inst_found = 1'b0;
        expect_val("pend_hold", exc_bundle(1'b1, 1'b1, 5'd3));
        expect_val("pend_hold_vaddr", 32'h0040_2000);
        tick();
        quiet();
        check(exc_bundle(exc_valid, exc_refill, exc_code));
        check(exc_vaddr);

        exc_ack = 1'b1;
        expect_val("ack_clear", 32'h0);
        tick();
        quiet();
        check(exc_bundle(exc_valid, exc_refill, exc_code));
        read_check("ack_badvaddr", 5'd8, 32'h0040_2000);
        read_check("ack_context", 5'd4, 32'hFF80_2010);
        read_check("ack_entryhi", 5'd10, 32'h0040_2078);

        // ---------------- flush in IDLE suppresses capture
        data_req   = 1'b1;
        data_found = 1'b0;
        flush      = 1'b1;
        expect_val("idle_flush", 32'h0);
        tick();
        quiet();
        check(exc_bundle(exc_valid, exc_refill, exc_code));

        // ---------------- inst invalid beats data Mod
        inst_req   = 1'b1;
        inst_vaddr = 32'h0000_1000;
        inst_found = 1'b1;
        inst_V     = 1'b0;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_vaddr = 32'h0040_3000;
        data_found = 1'b1;
        data_V     = 1'b1;
        data_D     = 1'b0;
        expect_val("inst_priority", exc_bundle(1'b1, 1'b0, 5'd2));
        expect_val("inst_priority_vaddr", 32'h0000_1000);
        tick();
        quiet();
        check(exc_bundle(exc_valid, exc_refill, exc_code));
        check(exc_vaddr);

        // ---------------- back-to-back fault on the ack edge
        exc_ack    = 1'b1;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_vaddr = 32'h0040_4000;
        data_found = 1'b0;
        expect_val("b2b_exc", exc_bundle(1'b1, 1'b1, 5'd2));
        expect_val("b2b_vaddr", 32'h0040_4000);
        tick();
        quiet();
        check(exc_bundle(exc_valid, exc_refill, exc_code));
        check(exc_vaddr);
        read_check("b2b_badvaddr", 5'd8, 32'h0000_1000);

        // ---------------- flush beats ack; unmapped never faults
        flush      = 1'b1;
        exc_ack    = 1'b1;
        data_req   = 1'b1;
        data_vaddr = 32'h8000_0000;
        data_found = 1'b0;
        expect_val("flush_over_ack", 32'h0);
        tick();
        flush   = 1'b0;
        exc_ack = 1'b0;
        check(exc_bundle(exc_valid, exc_refill, exc_code));
        read_check("flush_badvaddr", 5'd8, 32'h0000_1000);
        expect_val("unmapped", 32'h0);
        tick();
        quiet();
        check(exc_bundle(exc_valid, exc_refill, exc_code));

        // ---------------- Mod alone
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_vaddr = 32'h0050_0000;
        data_found = 1'b1;
        data_V     = 1'b1;
        data_D     = 1'b0;
        expect_val("mod", exc_bundle(1'b1, 1'b0, 5'd1));
        expect_val("mod_vaddr", 32'h0050_0000);
        tick();
        quiet();
        check(exc_bundle(exc_valid, exc_refill, exc_code));
        check(exc_vaddr);
        flush = 1'b1;
        expect_val("mod_flush", 32'h0);
        tick();
        quiet();
        check(exc_bundle(exc_valid, exc_refill, exc_code));

        // ---------------- TLBP suppresses data faults
        tlb_valid  = 1'b1;
        tlb_type   = 3'd1;
        Index_t    = 32'h8000_0000;
        data_req   = 1'b1;
        data_vaddr = 32'h0060_0000;
        data_found = 1'b0;
        expect_val("tlbp_no_fault", 32'h0);
        tick();
        quiet();
        check(exc_bundle(exc_valid, exc_refill, exc_code));

        // ---------------- async reset while pending
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_vaddr = 32'h0070_0000;
        data_found = 1'b0;
        expect_val("pre_reset_pend", exc_bundle(1'b1, 1'b1, 5'd2));
        tick();
        quiet();
        check(exc_bundle(exc_valid, exc_refill, exc_code));
        rst = 1'b1;
        #1;
        expect_val("async_rst_exc", 32'h0);        check(exc_bundle(exc_valid, exc_refill, exc_code));
        expect_val("async_rst_random", 32'h1F);    check(Random_o);
        read_check("async_rst_entryhi", 5'd10, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
